// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage ARM pipeline.
// Forms Val2 (offset / rotated immediate / shifted Rm), runs the ALU, computes the
// branch target, owns the NZCV status register and the EXE/MEM pipeline register.
// Optional macro EXE_FORWARDING_EN enables the Sel_src1/Sel_src2 forwarding muxes;
// without it the forwarding ports are present but ignored.
module exe_stage #(
   parameter int DATA_LEN             = 32,
   parameter int ADDRESS_LEN          = 32,
   parameter int ADDRESS_LEN_REG_FILE = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            freeze,
   input  logic [ADDRESS_LEN-1:0]          PC,
   input  logic [DATA_LEN-1:0]             Val_Rn,
   input  logic [DATA_LEN-1:0]             Val_Rm,
   input  logic                            WB_EN,
   input  logic                            MEM_R_EN,
   input  logic                            MEM_W_EN,
   input  logic                            B,
   input  logic                            S,
   input  logic                            imm,
   input  logic                            carry,
   input  logic [3:0]                      EXE_CMD,
   input  logic [ADDRESS_LEN_REG_FILE-1:0] Dest,
   input  logic [11:0]                     offset,
   input  logic [23:0]                     Signed_imm_24,
   input  logic [1:0]                      Sel_src1,
   input  logic [1:0]                      Sel_src2,
   input  logic [DATA_LEN-1:0]             MEM_fwd,
   input  logic [DATA_LEN-1:0]             WB_fwd,
   output logic                            Branch_taken,
   output logic [ADDRESS_LEN-1:0]          Branch_Address,
   output logic [3:0]                      SR,
   output logic                            WB_EN_out,
   output logic                            MEM_R_EN_out,
   output logic                            MEM_W_EN_out,
   output logic [DATA_LEN-1:0]             ALU_Res,
   output logic [DATA_LEN-1:0]             Store_Val,
   output logic [ADDRESS_LEN_REG_FILE-1:0] Dest_out
);

   localparam int M = DATA_LEN - 1;

   logic [DATA_LEN-1:0] op1, rm, val2, res;
   logic [DATA_LEN:0]   sum;
   logic                n_new, z_new, c_new, v_new;

   // Rotate right by amt; the doubled word makes amt = 0 a pass-through.
   function automatic logic [DATA_LEN-1:0] ror(input logic [DATA_LEN-1:0] v, input logic [4:0] amt);
      logic [2*DATA_LEN-1:0] t;
      t = {v, v} >> amt;
      return t[DATA_LEN-1:0];
   endfunction

`ifdef EXE_FORWARDING_EN
   // Operand forwarding muxes: 01 takes the MEM value, 10 the WB value, else the ID value.
   always_comb begin
      op1 = Val_Rn;
      rm  = Val_Rm;
      case (Sel_src1)
         2'b01:   op1 = MEM_fwd;
         2'b10:   op1 = WB_fwd;
         default: op1 = Val_Rn;
      endcase
      case (Sel_src2)
         2'b01:   rm = MEM_fwd;
         2'b10:   rm = WB_fwd;
         default: rm = Val_Rm;
      endcase
   end
`else
   // Forwarding disabled: operands come straight from the ID/EXE register.
   always_comb begin
      op1 = Val_Rn;
      rm  = Val_Rm;
   end
   wire unused_fwd = ^{Sel_src1, Sel_src2, MEM_fwd, WB_fwd};
`endif

   // Second operand: memory offset beats immediate beats shifted register.
   always_comb begin
      val2 = rm;
      if (MEM_R_EN | MEM_W_EN)
         val2 = DATA_LEN'(offset);
      else if (imm)
         val2 = ror(DATA_LEN'(offset[7:0]), {offset[11:8], 1'b0});
      else begin
         case (offset[6:5])
            2'b00:   val2 = rm << offset[11:7];
            2'b01:   val2 = rm >> offset[11:7];
            2'b10:   val2 = $signed(rm) >>> offset[11:7];
            default: val2 = ror(rm, offset[11:7]);
         endcase
      end
   end

   // ALU and next flags; logical ops and unknown codes keep C and V from SR.
   always_comb begin
      sum   = '0;
      res   = '0;
      c_new = SR[1];
      v_new = SR[0];
      case (EXE_CMD)
         4'b0001: res = val2;
         4'b1001: res = ~val2;
         4'b0010, 4'b0011: begin
            sum   = {1'b0, op1} + {1'b0, val2} + {{DATA_LEN{1'b0}}, (EXE_CMD[0] & carry)};
            res   = sum[M:0];
            c_new = sum[DATA_LEN];
            v_new = (op1[M] == val2[M]) && (res[M] != op1[M]);
         end
         4'b0100, 4'b0101: begin
            // op1 + ~val2 + 1 for SUB, + carry for SBC; bit 32 is the not-borrow
            sum   = {1'b0, op1} + {1'b0, ~val2} + {{DATA_LEN{1'b0}}, (EXE_CMD[0] ? carry : 1'b1)};
            res   = sum[M:0];
            c_new = sum[DATA_LEN];
            v_new = (op1[M] != val2[M]) && (res[M] != op1[M]);
         end
         4'b0110: res = op1 & val2;
         4'b0111: res = op1 | val2;
         4'b1000: res = op1 ^ val2;
         default: res = '0;
      endcase
      n_new = res[M];
      z_new = (res == '0);
   end

   assign Branch_taken   = B;
   assign Branch_Address = PC + {{(ADDRESS_LEN-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

   // Status register: updated by flag-setting instructions unless stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         SR <= '0;
      else if (!freeze && S)
         SR <= {n_new, z_new, c_new, v_new};
   end

   // EXE/MEM pipeline register: holds everything while frozen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         WB_EN_out    <= 1'b0;
         MEM_R_EN_out <= 1'b0;
         MEM_W_EN_out <= 1'b0;
         ALU_Res      <= '0;
         Store_Val    <= '0;
         Dest_out     <= '0;
      end else if (!freeze) begin
         WB_EN_out    <= WB_EN;
         MEM_R_EN_out <= MEM_R_EN;
         MEM_W_EN_out <= MEM_W_EN;
         ALU_Res      <= res;
         Store_Val    <= rm;
         Dest_out     <= Dest;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: table-driven vectors with a scoreboard queue, plus hand-written
// sequences for branch, forwarding, freeze and reset-during-freeze.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst, freeze;
   logic [31:0] PC, Val_Rn, Val_Rm, MEM_fwd, WB_fwd;
   logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, carry;
   logic [3:0]  EXE_CMD, Dest;
   logic [11:0] offset;
   logic [23:0] Signed_imm_24;
   logic [1:0]  Sel_src1, Sel_src2;
   logic        Branch_taken;
   logic [31:0] Branch_Address;
   logic [3:0]  SR;
   logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
   logic [31:0] ALU_Res, Store_Val;
   logic [3:0]  Dest_out;

   int passed = 0;
   int total  = 0;

   exe_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S), .imm(imm),
      .carry(carry), .EXE_CMD(EXE_CMD), .Dest(Dest), .offset(offset),
      .Signed_imm_24(Signed_imm_24), .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
      .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd), .Branch_taken(Branch_taken),
      .Branch_Address(Branch_Address), .SR(SR), .WB_EN_out(WB_EN_out),
      .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out), .ALU_Res(ALU_Res),
      .Store_Val(Store_Val), .Dest_out(Dest_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  cmd;
      logic [31:0] rn, rm;
      logic        imm, s, carry, wb, mr, mw;
      logic [11:0] off;
      logic [31:0] res;
      logic [3:0]  sr;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] res, st;
      logic [3:0]  sr, dest;
      logic        wb, mr, mw;
   } exp_t;

   vec_t v[19];
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   function automatic vec_t mk(input string nm, input logic [3:0] cmd, input logic [31:0] rn,
                               input logic [31:0] rm, input logic im, input logic [11:0] off,
                               input logic s, input logic c, input logic wb, input logic mr,
                               input logic mw, input logic [31:0] res, input logic [3:0] sr);
      vec_t t;
      t.name = nm; t.cmd = cmd; t.rn = rn; t.rm = rm; t.imm = im; t.off = off; t.s = s;
      t.carry = c; t.wb = wb; t.mr = mr; t.mw = mw; t.res = res; t.sr = sr;
      return t;
   endfunction

   // drive one instruction at the falling edge and record what it must produce
   task automatic drive(input vec_t t, input logic [3:0] dst);
      exp_t e;
      @(negedge clk);
      Val_Rn = t.rn; Val_Rm = t.rm; EXE_CMD = t.cmd; imm = t.imm; offset = t.off; S = t.s;
      carry = t.carry; WB_EN = t.wb; MEM_R_EN = t.mr; MEM_W_EN = t.mw; Dest = dst;
      B = 1'b0; PC = '0; Signed_imm_24 = '0; Sel_src1 = 2'b00; Sel_src2 = 2'b00;
      e.name = t.name; e.res = t.res; e.st = t.rm; e.sr = t.sr; e.dest = dst;
      e.wb = t.wb; e.mr = t.mr; e.mw = t.mw;
      sb.push_back(e);
   endtask

   // after the edge, pop the oldest expectation and compare
   task automatic collect();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         chk({e.name, "_res"},  ALU_Res,             e.res);
         chk({e.name, "_sr"},   {28'd0, SR},         {28'd0, e.sr});
         chk({e.name, "_ctl"},  {29'd0, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out},
                                {29'd0, e.wb, e.mr, e.mw});
         chk({e.name, "_st"},   Store_Val,           e.st);
         chk({e.name, "_dest"}, {28'd0, Dest_out},   {28'd0, e.dest});
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_res"}, ALU_Res, 32'd0);
      chk({nm, "_st"},  Store_Val, 32'd0);
      chk({nm, "_sr"},  {28'd0, SR}, 32'd0);
      chk({nm, "_ctl"}, {28'd0, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, 1'b0}, 32'd0);
      chk({nm, "_dest"}, {28'd0, Dest_out}, 32'd0);
   endtask

   initial begin
      vec_t f;
      logic [31:0] fwd_exp;
      //          name        cmd     rn           rm           imm off     s  c  wb mr mw res          sr
      v[0]  = mk("add_imm",  4'b0010, 32'd5,       32'd0,       1, 12'h003, 0, 0, 1, 0, 0, 32'd8,       4'h0);
      v[1]  = mk("subs_eq",  4'b0100, 32'd3,       32'd3,       0, 12'h000, 1, 0, 1, 0, 0, 32'd0,       4'h6);
      v[2]  = mk("adc",      4'b0011, 32'd1,       32'd0,       1, 12'h001, 0, 1, 1, 0, 0, 32'd3,       4'h6);
      v[3]  = mk("movs_rot", 4'b0001, 32'd0,       32'd0,       1, 12'h4FF, 1, 0, 1, 0, 0, 32'hFF000000, 4'hA);
      v[4]  = mk("asr4",     4'b0001, 32'd0,       32'h80000000, 0, 12'h240, 0, 0, 1, 0, 0, 32'hF8000000, 4'hA);
      v[5]  = mk("ror8",     4'b0001, 32'd0,       32'h000000AB, 0, 12'h460, 0, 0, 1, 0, 0, 32'hAB000000, 4'hA);
      v[6]  = mk("mvn",      4'b1001, 32'd0,       32'd0,       1, 12'h000, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 4'hA);
      v[7]  = mk("ldr",      4'b0010, 32'h100,     32'd0,       0, 12'hFFF, 0, 0, 1, 1, 0, 32'h10FF,    4'hA);
      v[8]  = mk("str",      4'b0010, 32'h20,      32'hDEAD,    0, 12'h004, 0, 0, 0, 0, 1, 32'h24,      4'hA);
      v[9]  = mk("subs_ovf", 4'b0100, 32'h80000000, 32'd0,      1, 12'h001, 1, 0, 1, 0, 0, 32'h7FFFFFFF, 4'h3);
      v[10] = mk("adds_c",   4'b0010, 32'hFFFFFFFF, 32'd0,      1, 12'h001, 1, 0, 1, 0, 0, 32'd0,       4'h6);
      v[11] = mk("sbcs",     4'b0101, 32'd5,       32'd0,       1, 12'h002, 1, 0, 1, 0, 0, 32'd2,       4'h2);
      v[12] = mk("ands",     4'b0110, 32'hF0F0,    32'd0,       1, 12'h0FF, 1, 0, 1, 0, 0, 32'hF0,      4'h2);
      v[13] = mk("orr",      4'b0111, 32'hF00,     32'd0,       1, 12'h0F0, 0, 0, 1, 0, 0, 32'hFF0,     4'h2);
      v[14] = mk("eor",      4'b1000, 32'hFF,      32'd0,       1, 12'h00F, 0, 0, 1, 0, 0, 32'hF0,      4'h2);
      v[15] = mk("unk",      4'b1111, 32'h1234,    32'd0,       1, 12'h0FF, 1, 0, 1, 0, 0, 32'd0,       4'h6);
      v[16] = mk("lsl31",    4'b0001, 32'd0,       32'd1,       0, 12'hF80, 0, 0, 1, 0, 0, 32'h80000000, 4'h6);
      v[17] = mk("lsr1",     4'b0001, 32'd0,       32'h80000000, 0, 12'h0A0, 0, 0, 1, 0, 0, 32'h40000000, 4'h6);
      v[18] = mk("flush",    4'b0000, 32'd0,       32'd0,       0, 12'h000, 0, 0, 0, 0, 0, 32'd0,       4'h6);

      rst = 1'b0; freeze = 1'b0; PC = '0; Val_Rn = 32'd9; Val_Rm = 32'd9; WB_EN = 1'b1;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; B = 1'b0; S = 1'b1; imm = 1'b1; carry = 1'b0;
      EXE_CMD = 4'b0010; Dest = 4'd7; offset = 12'h001; Signed_imm_24 = '0;
      Sel_src1 = 2'b00; Sel_src2 = 2'b00; MEM_fwd = '0; WB_fwd = '0;

      // reset holds every registered output at zero despite live inputs
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (v[i]) begin
         drive(v[i], 4'(i));
         collect();
      end

      // branch outputs are combinational in the same cycle as B
      @(negedge clk);
      B = 1'b1; PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
      #1;
      chk("branch_taken", {31'd0, Branch_taken}, 32'd1);
      chk("branch_addr",  Branch_Address, 32'hF8);
      Signed_imm_24 = 24'h000010;
      #1;
      chk("branch_fwd_addr", Branch_Address, 32'h140);
      B = 1'b0;
      #1;
      chk("branch_off", {31'd0, Branch_taken}, 32'd0);

      // forwarding of Rn from MEM; without the feature the ID value is used
`ifdef EXE_FORWARDING_EN
      fwd_exp = 32'd12;
`else
      fwd_exp = 32'd9;
`endif
      f = mk("fwd_mem", 4'b0010, 32'd7, 32'd0, 1, 12'h002, 0, 0, 1, 0, 0, fwd_exp, 4'h6);
      drive(f, 4'd3);
      Sel_src1 = 2'b01; MEM_fwd = 32'd10;
      collect();
      f = mk("fwd_sel11", 4'b0010, 32'd7, 32'd0, 1, 12'h002, 0, 0, 1, 0, 0, 32'd9, 4'h6);
      drive(f, 4'd4);
      Sel_src1 = 2'b11;
      collect();

      // freeze for three cycles with a flag-setting add pending
      f = mk("pre_frz", 4'b0010, 32'd7, 32'd0, 1, 12'h003, 0, 0, 1, 0, 0, 32'd10, 4'h6);
      drive(f, 4'd5);
      collect();
      @(negedge clk);
      freeze = 1'b1; Val_Rn = 32'd1; imm = 1'b1; offset = 12'h001; S = 1'b1;
      WB_EN = 1'b0; Dest = 4'd9;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("frz_res",  ALU_Res, 32'd10);
         chk("frz_sr",   {28'd0, SR}, 32'h6);
         chk("frz_wb",   {31'd0, WB_EN_out}, 32'd1);
      end
      @(negedge clk);
      freeze = 1'b0;
      @(posedge clk);
      #1;
      chk("unfrz_res",  ALU_Res, 32'd2);
      chk("unfrz_sr",   {28'd0, SR}, 32'h0);
      chk("unfrz_dest", {28'd0, Dest_out}, 32'd9);

      // reset in the middle of a freeze clears everything at once
      @(negedge clk);
      freeze = 1'b1; Val_Rn = 32'h80000000; offset = 12'h000;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("rst_in_frz");
      @(negedge clk);
      rst = 1'b1; freeze = 1'b0;

      if (sb.size() != 0) begin
         total++;
         $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
